// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: control FSM for the memory-sequence game.
// Optional play timeout is built only when CONTROLE_TIMEOUT_EN is defined.
module unidade_controle_jogo #(
  parameter int N_RODADAS      = 16,
  parameter int TIMEOUT_CICLOS = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       jogada,
  input  logic       igual,
  output logic [3:0] endereco,
  output logic [3:0] rodada,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    COMPARA     = 4'h3,
    PROX_JOGADA = 4'h4,
    PROX_RODADA = 4'h5,
    FIM_ACERTO  = 4'hA,
`ifdef CONTROLE_TIMEOUT_EN
    FIM_TIMEOUT = 4'hD,
`endif
    FIM_ERRO    = 4'hE
  } estado_t;

  localparam logic [3:0] ULTIMA = 4'(N_RODADAS - 1);

  estado_t    estado_q, estado_d;
  logic [3:0] end_q, end_d;
  logic [3:0] rod_q, rod_d;
  logic       igual_q, igual_d;
  logic       fim_tempo;

`ifdef CONTROLE_TIMEOUT_EN
  localparam int TW =
    (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT_CICLOS - 1);

  logic [TW-1:0] timer_q, timer_d;

  // Play timer: cleared on every new play slot, saturating count in ESPERA
  always_comb begin
    timer_d = timer_q;
    case (estado_q)
      PREPARA,
      PROX_JOGADA,
      PROX_RODADA: timer_d = '0;
      ESPERA: begin
        if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: timer_d = timer_q;
    endcase
  end

  // Timer register
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign fim_tempo = (timer_q == LIMITE);
`else
  localparam int unused_timeout_ciclos = TIMEOUT_CICLOS;
  assign fim_tempo = 1'b0;
`endif

  // Next state and counter updates; jogada only matters in ESPERA
  always_comb begin
    estado_d = estado_q;
    end_d    = end_q;
    rod_d    = rod_q;
    igual_d  = igual_q;
    case (estado_q)
      INICIAL: begin
        if (jogar) begin
          estado_d = PREPARA;
        end
      end
      PREPARA: begin
        end_d    = 4'd0;
        rod_d    = 4'd0;
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (jogada) begin
          igual_d  = igual;
          estado_d = COMPARA;
        end
`ifdef CONTROLE_TIMEOUT_EN
        else if (fim_tempo) begin
          estado_d = FIM_TIMEOUT;
        end
`endif
      end
      COMPARA: begin
        if (!igual_q) begin
          estado_d = FIM_ERRO;
        end else if (end_q != rod_q) begin
          estado_d = PROX_JOGADA;
        end else if (rod_q == ULTIMA) begin
          estado_d = FIM_ACERTO;
        end else begin
          estado_d = PROX_RODADA;
        end
      end
      PROX_JOGADA: begin
        end_d    = end_q + 4'd1;
        estado_d = ESPERA;
      end
      PROX_RODADA: begin
        rod_d    = rod_q + 4'd1;
        end_d    = 4'd0;
        estado_d = ESPERA;
      end
`ifdef CONTROLE_TIMEOUT_EN
      FIM_TIMEOUT,
`endif
      FIM_ACERTO,
      FIM_ERRO: begin
        if (jogar) begin
          estado_d = PREPARA;
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  // State, counters and latched comparison
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      end_q    <= 4'd0;
      rod_q    <= 4'd0;
      igual_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      end_q    <= end_d;
      rod_q    <= rod_d;
      igual_q  <= igual_d;
    end
  end

  // Moore status outputs decoded from the state
  always_comb begin
    ganhou  = 1'b0;
    perdeu  = 1'b0;
    timeout = 1'b0;
    pronto  = 1'b0;
    case (estado_q)
      FIM_ACERTO: begin
        ganhou = 1'b1;
        pronto = 1'b1;
      end
      FIM_ERRO: begin
        perdeu = 1'b1;
        pronto = 1'b1;
      end
`ifdef CONTROLE_TIMEOUT_EN
      FIM_TIMEOUT: begin
        perdeu  = 1'b1;
        timeout = 1'b1;
        pronto  = 1'b1;
      end
`endif
      default: begin
        ganhou  = 1'b0;
        perdeu  = 1'b0;
        timeout = 1'b0;
        pronto  = 1'b0;
      end
    endcase
  end

  assign endereco  = end_q;
  assign rodada    = rod_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb_unidade_controle_jogo: vector table, directed game sequences
// and randomized games against a rule-level model.
module tb_unidade_controle_jogo;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic       jogada;
  logic       igual;
  logic [3:0] endereco;
  logic [3:0] rodada;
  logic       ganhou;
  logic       perdeu;
  logic       timeout;
  logic       pronto;
  logic [3:0] db_estado;

  int n_vec = 0;
  int n_err = 0;

  unidade_controle_jogo #(
    .N_RODADAS(16),
    .TIMEOUT_CICLOS(3000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .jogar(jogar),
    .jogada(jogada),
    .igual(igual),
    .endereco(endereco),
    .rodada(rodada),
    .ganhou(ganhou),
    .perdeu(perdeu),
    .timeout(timeout),
    .pronto(pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       rst;
    logic       jog;
    logic       jd;
    logic       ig;
    logic [3:0] est;
    logic [3:0] ende;
    logic [3:0] rod;
    logic       g;
    logic       p;
    logic       pr;
    logic       cc;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] est,
                         input logic [3:0] e_end, input logic [3:0] e_rod,
                         input logic g, input logic p, input logic pr,
                         input logic to, input logic cc);
    chk({tag, ".estado"}, 32'(db_estado), 32'(est));
    if (cc) begin
      chk({tag, ".endereco"}, 32'(endereco), 32'(e_end));
      chk({tag, ".rodada"}, 32'(rodada), 32'(e_rod));
    end
    chk({tag, ".ganhou"}, 32'(ganhou), 32'(g));
    chk({tag, ".perdeu"}, 32'(perdeu), 32'(p));
    chk({tag, ".pronto"}, 32'(pronto), 32'(pr));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  // Rule-level model of one game: round k needs k+1 correct plays.
  task automatic play_game(input int gid);
    int  k;
    int  p;
    bit  done;
    bit  ig;
    logic [3:0] est;
    bit  g;
    bit  l;
    k = 0;
    p = 0;
    done = 0;
    g = 0;
    l = 0;
    jogar = 1'b1;
    step();
    jogar = 1'b0;
    step();
    chk_all($sformatf("g%0d.start", gid), 4'h2, 4'd0, 4'd0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    while (!done) begin
      repeat ($urandom_range(0, 5)) step();
      ig = ($urandom_range(0, 39) != 0);
      jogada = 1'b1;
      igual  = ig;
      step();
      jogada = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        jogada = 1'b1;
        igual  = 1'($urandom);
      end
      step();
      jogada = ($urandom_range(0, 1) == 1);
      igual  = 1'($urandom);
      step();
      jogada = 1'b0;
      if (!ig) begin
        l = 1;
        done = 1;
      end else if (p < k) begin
        p++;
      end else if (k == 15) begin
        g = 1;
        done = 1;
      end else begin
        k++;
        p = 0;
      end
      est = g ? 4'hA : (l ? 4'hE : 4'h2);
      chk_all($sformatf("g%0d.k%0d.p%0d", gid, k, p), est, 4'(p), 4'(k),
              g, l, g | l, 1'b0, 1'b1);
    end
  endtask

  initial begin
    int cyc;
    int r;
    int need;
    reset  = 1'b1;
    jogar  = 1'b0;
    jogada = 1'b0;
    igual  = 1'b0;

    // rst jog jd ig  est  end  rod  g p pr cc
    vt[0]  = '{1, 0, 0, 0, 4'h0, 4'd0, 4'd0, 0, 0, 0, 1};
    vt[1]  = '{0, 1, 0, 0, 4'h1, 4'd0, 4'd0, 0, 0, 0, 1};
    vt[2]  = '{0, 1, 0, 0, 4'h2, 4'd0, 4'd0, 0, 0, 0, 1};
    vt[3]  = '{0, 1, 0, 0, 4'h2, 4'd0, 4'd0, 0, 0, 0, 1};
    vt[4]  = '{0, 1, 0, 0, 4'h2, 4'd0, 4'd0, 0, 0, 0, 1};
    vt[5]  = '{0, 1, 0, 0, 4'h2, 4'd0, 4'd0, 0, 0, 0, 1};
    vt[6]  = '{0, 0, 1, 1, 4'h3, 4'd0, 4'd0, 0, 0, 0, 1};
    vt[7]  = '{0, 0, 0, 0, 4'h5, 4'd0, 4'd0, 0, 0, 0, 1};
    vt[8]  = '{0, 0, 0, 0, 4'h2, 4'd0, 4'd1, 0, 0, 0, 1};
    vt[9]  = '{0, 0, 1, 1, 4'h3, 4'd0, 4'd1, 0, 0, 0, 1};
    vt[10] = '{0, 0, 1, 0, 4'h4, 4'd0, 4'd1, 0, 0, 0, 1};
    vt[11] = '{0, 0, 0, 0, 4'h2, 4'd1, 4'd1, 0, 0, 0, 1};
    vt[12] = '{0, 0, 1, 0, 4'h3, 4'd1, 4'd1, 0, 0, 0, 1};
    vt[13] = '{0, 0, 0, 0, 4'hE, 4'd1, 4'd1, 0, 1, 1, 1};
    vt[14] = '{0, 0, 1, 1, 4'hE, 4'd1, 4'd1, 0, 1, 1, 1};
    vt[15] = '{0, 1, 0, 0, 4'h1, 4'd0, 4'd0, 0, 0, 0, 0};
    vt[16] = '{0, 0, 0, 0, 4'h2, 4'd0, 4'd0, 0, 0, 0, 1};
    vt[17] = '{0, 0, 1, 1, 4'h3, 4'd0, 4'd0, 0, 0, 0, 1};
    vt[18] = '{1, 0, 0, 0, 4'h0, 4'd0, 4'd0, 0, 0, 0, 1};
    vt[19] = '{0, 0, 0, 0, 4'h0, 4'd0, 4'd0, 0, 0, 0, 1};

    for (int i = 0; i < 20; i++) begin
      reset  = vt[i].rst;
      jogar  = vt[i].jog;
      jogada = vt[i].jd;
      igual  = vt[i].ig;
      step();
      chk_all($sformatf("vec%0d", i), vt[i].est, vt[i].ende, vt[i].rod,
              vt[i].g, vt[i].p, vt[i].pr, 1'b0, vt[i].cc);
    end
    reset  = 1'b0;
    jogar  = 1'b0;
    jogada = 1'b0;
    igual  = 1'b0;

    // Full win: 136 correct plays spaced 20 cycles
    jogar = 1'b1;
    step();
    jogar = 1'b0;
    step();
    for (int n = 1; n <= 136; n++) begin
      jogada = 1'b1;
      igual  = 1'b1;
      step();
      jogada = 1'b0;
      igual  = 1'b0;
      repeat (19) step();
      if (n == 1 || n == 2 || n == 3 || n == 6 || n == 10) begin
        r = 0;
        need = 1;
        while (need <= n) begin
          r++;
          need += r + 1;
        end
        chk($sformatf("win.rodada@%0d", n), 32'(rodada), 32'(r));
      end
    end
    chk_all("win", 4'hA, 4'd15, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // Randomized games, each restarted from a FIM state
    for (int gi = 0; gi < 6; gi++) begin
      play_game(gi);
    end

`ifdef CONTROLE_TIMEOUT_EN
    jogar = 1'b1;
    step();
    jogar = 1'b0;
    step();
    cyc = 0;
    while (db_estado == 4'h2 && cyc < 3100) begin
      step();
      cyc++;
    end
    chk("to.ciclos", 32'(cyc), 32'd3000);
    chk_all("to", 4'hD, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    jogar = 1'b1;
    step();
    jogar = 1'b0;
    step();
    repeat (2999) step();
    jogada = 1'b1;
    igual  = 1'b1;
    step();
    jogada = 1'b0;
    chk_all("to.ultimo", 4'h3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    jogar = 1'b1;
    step();
    jogar = 1'b0;
    step();
    cyc = 0;
    repeat (10000) step();
    chk_all("idle", 4'h2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unidade_controle_jogo.md
# unidade_controle_jogo

Control unit for the memory-sequence game (the "jogo de sequências"). It sequences the game datapath:
- owns the round counter (`rodada`) and the play-position counter (`endereco`) that addresses the sequence memory;
- owns the per-play timeout timer;
- consumes the datapath's one-cycle play strobe and memory-vs-button comparison;
- produces the game status outputs (`ganhou`, `perdeu`, `pronto`) plus a state code for the 7-segment debug display.

## Interface
Parameters:
- `N_RODADAS`, default 16: rounds to win; legal range 1..16. Round k (0-based) requires k+1 plays.
- `TIMEOUT_CICLOS`, default 3000: maximum clock cycles spent waiting for one play.

Ports:
- `clock`  in  1: single clock; every register updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `jogar`  in  1: start/restart request; a level is tolerated.
- `jogada`  in  1: one-cycle pulse from the button edge detector (a play was made).
- `igual`  in  1: sequence-memory word at `endereco` equals the pressed button code; valid in the cycle `jogada`=1.
- `endereco`  out  4: sequence-memory address (current play position).
- `rodada`  out  4: current round index.
- `ganhou`  out  1: game won.
- `perdeu`  out  1: game lost (error or timeout).
- `timeout`  out  1: loss was caused by timeout.
- `pronto`  out  1: game finished.
- `db_estado`  out  4: current state code.

## Operation
All outputs are Moore outputs: they are decoded from the state register or are registers themselves.

States (code):
- INICIAL (0x0): all outputs 0. `jogar`=1 → PREPARA.
- PREPARA (0x1): clears `rodada`, `endereco` and the timer. Next state ESPERA unconditionally.
- ESPERA (0x2): timer increments each cycle. Transitions, in priority order:
  - `jogada`=1 → latch `igual` into `igual_r`; next state COMPARA.
  - timer == `TIMEOUT_CICLOS`-1 → FIM_TIMEOUT.
- COMPARA (0x3): decides on `igual_r`:
  - `igual_r`=0 → FIM_ERRO.
  - `endereco`≠`rodada` → PROX_JOGADA.
  - `rodada`=`N_RODADAS`-1 → FIM_ACERTO.
  - otherwise → PROX_RODADA.
- PROX_JOGADA (0x4): `endereco`+1; timer cleared; next state ESPERA.
- PROX_RODADA (0x5): `rodada`+1; `endereco`←0; timer cleared; next state ESPERA.
- FIM_ACERTO (0xA): `ganhou`=1, `pronto`=1.
- FIM_ERRO (0xE): `perdeu`=1, `pronto`=1.
- FIM_TIMEOUT (0xD): `perdeu`=1, `timeout`=1, `pronto`=1.

In all three FIM states, `jogar`=1 → PREPARA; otherwise the state holds.

Rules:
- `jogada` is ignored in every state except ESPERA. `jogar` is ignored outside INICIAL and the FIM states.
- `endereco` and `rodada` hold their values in the FIM states, so the failing position is visible on the debug display.
- Counters are 4 bits and never wrap: the COMPARA checks bound them to `N_RODADAS`-1.
- Timer width is $clog2(`TIMEOUT_CICLOS`). It saturates and never wraps.
- Unused state codes → INICIAL on the next edge.

## Timing
- Reset is synchronous: at the first rising edge with `reset`=1, state ← INICIAL and every register ← 0. All outputs are 0 from that edge on. This applies even mid-game, e.g. in COMPARA.
- Start latency: `jogar` sampled high at edge t → PREPARA after t, ESPERA after t+1.
- Play latency: `jogada` sampled at edge t → COMPARA after t → next state after t+1. Updated `endereco`/`rodada` are visible after t+2; ESPERA resumes after t+2.
- Minimum spacing between `jogada` pulses is 3 cycles; pulses arriving outside ESPERA are dropped.
- Timeout: ESPERA entered with timer=0 → FIM_TIMEOUT is entered exactly `TIMEOUT_CICLOS` cycles later if no `jogada` arrives.
- `jogada` in the final timeout cycle wins over the timeout.
- Status outputs assert in the first cycle of the FIM state.

## Configuration
- `CONTROLE_TIMEOUT_EN` defined: timer, FIM_TIMEOUT state and `timeout` output are implemented as described above.
- Not defined:
  - no timer logic is built;
  - `timeout` is tied to 0;
  - ESPERA waits indefinitely;
  - FIM_TIMEOUT does not exist, and code 0xD falls into the unused-code rule.

## Test plan
- Reset, then `jogar`=1 for 5 cycles → `db_estado` 0x0→0x1→0x2; `endereco`=0, `rodada`=0; `pronto`=0 throughout.
- Full win with `N_RODADAS`=16: 136 `jogada` pulses, each with `igual`=1, spaced 20 cycles → `rodada` increments after plays 1, 3, 6, …. After the last play: `ganhou`=1, `pronto`=1, `db_estado`=0xA, `rodada`=15, `endereco`=15.
- Error in round 1 (first play correct, second play `igual`=0) → `perdeu`=1, `pronto`=1, `ganhou`=0, `db_estado`=0xE, `rodada`=1, `endereco`=1.
- Timeout (macro defined, `TIMEOUT_CICLOS`=3000): no `jogada` after start → exactly 3000 cycles in 0x2, then `timeout`=1, `perdeu`=1, `db_estado`=0xD. Repeat with `jogada`+`igual` in cycle 3000 → COMPARA (0x3), no timeout.
- Restart and reset:
  - From 0xE, `jogar`=1 → 0x1, then 0x2, with `perdeu`=0, `endereco`=0, `rodada`=0.
  - `reset`=1 during COMPARA → `db_estado`=0x0 and all outputs 0 after that edge.
- Macro undefined: 10000 idle cycles in ESPERA → state stays 0x2; `timeout`=0; `perdeu`=0.
